// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - lsu_state_e : LSU sequencing states (IDLE, ACCESS, MERGE, RESP)
//   - f3_legal()  : funct3/direction legality check
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Stores only exist as B/H/W; the unsigned encodings are load-only.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational lane handling for the LSU.
//   Load path : picks the byte/halfword addressed by addr_lo out of rdata and
//               sign- or zero-extends it (W returns the whole word).
//   Store path: replaces the addressed byte/halfword of old_word with the low
//               bits of store_data (used for SB/SH read-modify-write).
// Ports:
//   funct3      in  3            access size/signedness
//   addr_lo     in  2            byte offset within the word
//   rdata       in  WORD_LENGTH  word read from RAM (load source)
//   old_word    in  WORD_LENGTH  captured word to merge into
//   store_data  in  16           low bits of the store data
//   load_data   out WORD_LENGTH  extended load result
//   merged_word out WORD_LENGTH  old_word with the addressed lane replaced
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic [2:0]             funct3,
  input  logic [1:0]             addr_lo,
  input  logic [WORD_LENGTH-1:0] rdata,
  input  logic [WORD_LENGTH-1:0] old_word,
  input  logic [15:0]            store_data,
  output logic [WORD_LENGTH-1:0] load_data,
  output logic [WORD_LENGTH-1:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Halfwords use only addr[1]: a misaligned halfword resolves to its aligned lane.
  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{(WORD_LENGTH-8){byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {{(WORD_LENGTH-8){1'b0}}, byte_lane};
      F3_H:    load_data = {{(WORD_LENGTH-16){half_lane[15]}}, half_lane};
      F3_HU:   load_data = {{(WORD_LENGTH-16){1'b0}}, half_lane};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged_word = old_word;
    if (funct3 == F3_B)
      merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
    else if (funct3 == F3_H)
      merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data;
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store initiator on the data port of a word-addressed RAM.
//   Converts byte-address LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
//   Loads: one RAM read, lane extract + extend. SW: one RAM write.
//   SB/SH: read in ACCESS, merged word written in MERGE.
//   Sequence: IDLE -> ACCESS -> [MERGE] -> RESP -> IDLE; illegal requests
//   go IDLE -> RESP directly with resp_err.
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned H/HU (addr[0]) and W
//                         (addr[1:0]) accesses are rejected with resp_err
//                         instead of using the aligned lane.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_funct3          store flag, RV32I access size
//   req_addr, req_wdata         byte address, store data
//   resp_valid                  one-cycle completion pulse
//   resp_rdata, resp_err        load data (0 for stores/errors), error flag
//   mem_addr                    RAM word index (wraps modulo NUM_MEM)
//   mem_write_en, mem_wdata     RAM write strobe and full-word data
//   mem_dout                    RAM combinational read data
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_MEM     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic                   mem_write_en,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic [WORD_LENGTH-1:0] mem_dout
);

  localparam int IDX_W = $clog2(NUM_MEM);

  lsu_state_e             state;
  logic                   we_q;
  logic [2:0]             f3_q;
  logic [IDX_W+1:0]       addr_q;   // only the bits that survive the index wrap
  logic [15:0]            wdata_q;  // sub-word stores need no more than this
  logic [WORD_LENGTH-1:0] wdata_full_q;
  logic [WORD_LENGTH-1:0] old_word_q;
  logic [WORD_LENGTH-1:0] load_data;
  logic [WORD_LENGTH-1:0] merged_word;
  logic                   req_bad;
  logic                   unused_addr_bits;

  // Upper byte-address bits fall outside the wrapped RAM index.
  assign unused_addr_bits = ^req_addr[WORD_LENGTH-1:IDX_W+2];

  always_comb begin
    req_bad = !f3_legal(req_funct3, req_we);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
      req_bad = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
      req_bad = 1'b1;
`endif
  end

  riscv_lsu_align #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_dout),
    .old_word   (old_word_q),
    .store_data (wdata_q),
    .load_data  (load_data),
    .merged_word(merged_word)
  );

  // RAM port is decoded from the registered request and state.
  assign mem_addr = {{(WORD_LENGTH-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};

  // The strobe is gated with rst so a reset landing on a write cycle drops the write.
  assign mem_write_en = !rst &&
                        ((state == ACCESS && we_q && f3_q == F3_W) || state == MERGE);

  always_comb begin
    mem_wdata = '0;
    if (state == ACCESS && we_q)
      mem_wdata = wdata_full_q;
    else if (state == MERGE)
      mem_wdata = merged_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= F3_B;
      addr_q       <= '0;
      wdata_q      <= '0;
      wdata_full_q <= '0;
      old_word_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            f3_q         <= req_funct3;
            addr_q       <= req_addr[IDX_W+1:0];
            wdata_q      <= req_wdata[15:0];
            wdata_full_q <= req_wdata;
            req_ready    <= 1'b0;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (f3_q == F3_W) begin
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            old_word_q <= mem_dout;
            state      <= MERGE;
          end
        end
        MERGE: begin
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed self-checking bench for riscv_lsu (NUM_MEM=4096).
// A small word RAM with combinational read sits on the data port; writes
// seen on mem_write_en are applied at the clock edge and logged.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  riscv_lsu #(.WORD_LENGTH(32), .NUM_MEM(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_write_en(mem_write_en),
    .mem_wdata   (mem_wdata),
    .mem_dout    (mem_dout)
  );

  always #5 clk = ~clk;

  // RAM model plus write/response logging.
  logic [31:0] ram [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_idx;
  logic [31:0] poke_data;
  int          cyc = 0;
  int          wr_count = 0;
  int          resp_count = 0;
  int          last_wr_cyc = -1;
  logic [31:0] last_wr_idx = '0;
  logic [31:0] last_wr_data = '0;
  int          acc_cyc;

  assign mem_dout = ram[mem_addr[11:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) ram[poke_idx] <= poke_data;
    if (mem_write_en) begin
      ram[mem_addr[11:0]] <= mem_wdata;
      wr_count     <= wr_count + 1;
      last_wr_idx  <= mem_addr;
      last_wr_data <= mem_wdata;
      last_wr_cyc  <= cyc;
    end
    if (resp_valid) resp_count <= resp_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [11:0] idx, input logic [31:0] data);
    @(negedge clk);
    poke_idx  = idx;
    poke_data = data;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // Issues one request, returns latency in cycles after acceptance (-1 on timeout).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat,
                       output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int k = 0; k < 10 && !req_ready; k++) @(negedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = F3_W;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready=%b valid=%b err=%b, want 1 0 0", req_ready, resp_valid, resp_err);
    end
    checks++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h we=%b, want all 0",
               resp_rdata, mem_addr, mem_wdata, mem_write_en);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_store_word;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = wr_count;
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rd, er);
    checks++;
    if (lat != 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL sw_latency: lat=%0d err=%b, want 2 0", lat, er);
    end
    checks++;
    if (wr_count != w0 + 1 || last_wr_idx !== 32'd4 || last_wr_data !== 32'hDEADBEEF ||
        last_wr_cyc != acc_cyc + 1) begin
      errors++;
      $display("FAIL sw_write: n=%0d idx=%0d data=%h cyc=%0d, want n=%0d idx=4 data=deadbeef cyc=%0d",
               wr_count - w0, last_wr_idx, last_wr_data, last_wr_cyc, 1, acc_cyc + 1);
    end
    w0 = wr_count;
    issue(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (lat != 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || wr_count != w0) begin
      errors++;
      $display("FAIL lw_readback: lat=%0d rdata=%h err=%b writes=%0d, want 2 deadbeef 0 0",
               lat, rd, er, wr_count - w0);
    end
  endtask

  task automatic test_load_lanes;
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    int lat; logic [31:0] rd; logic er;
    poke(12'd4, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, er);
      checks++;
      if (lat != 2 || rd !== exps[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL load_lane_%0d: lat=%0d rdata=%h err=%b, want 2 %h 0", i, lat, rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_subword_store;
    int lat; logic [31:0] rd; logic er; int w0;
    poke(12'd4, 32'h80FF7F01);
    w0 = wr_count;
    issue(1'b1, F3_B, 32'h11, 32'h123456AA, lat, rd, er);
    checks++;
    if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sb_latency: lat=%0d err=%b rdata=%h, want 3 0 0", lat, er, rd);
    end
    checks++;
    if (wr_count != w0 + 1 || last_wr_idx !== 32'd4 || last_wr_data !== 32'h80FFAA01 ||
        last_wr_cyc != acc_cyc + 2) begin
      errors++;
      $display("FAIL sb_merge: n=%0d idx=%0d data=%h cyc=%0d, want n=1 idx=4 data=80ffaa01 cyc=%0d",
               wr_count - w0, last_wr_idx, last_wr_data, last_wr_cyc, acc_cyc + 2);
    end
    poke(12'd4, 32'h80FF7F01);
    w0 = wr_count;
    issue(1'b1, F3_H, 32'h12, 32'hABCD1234, lat, rd, er);
    checks++;
    if (lat != 3 || wr_count != w0 + 1 || last_wr_data !== 32'h12347F01) begin
      errors++;
      $display("FAIL sh_merge: lat=%0d n=%0d data=%h, want 3 1 12347f01", lat, wr_count - w0, last_wr_data);
    end
  endtask

  task automatic test_misalign;
    int lat; logic [31:0] rd; logic er; int w0;
    poke(12'd4, 32'h11223344);
    w0 = wr_count;
    issue(1'b0, F3_W, 32'h12, 32'h0, lat, rd, er);
    checks++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || wr_count != w0) begin
      errors++;
      $display("FAIL lw_misalign_trap: lat=%0d err=%b rdata=%h writes=%0d, want 1 1 0 0",
               lat, er, rd, wr_count - w0);
    end
`else
    if (lat != 2 || er !== 1'b0 || rd !== 32'h11223344 || wr_count != w0) begin
      errors++;
      $display("FAIL lw_misalign_aligned: lat=%0d err=%b rdata=%h writes=%0d, want 2 0 11223344 0",
               lat, er, rd, wr_count - w0);
    end
`endif
  endtask

  task automatic test_reset_mid_merge;
    int w0; int r0;
    poke(12'd4, 32'h80FF7F01);
    w0 = wr_count; r0 = resp_count;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h11; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(negedge clk);  // ACCESS
    req_valid = 1'b0;
    @(negedge clk);  // MERGE
    rst = 1'b1;
    #1;
    checks++;
    if (mem_write_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_gates_write_en: got %b want 0", mem_write_en);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_merge_state: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
    end
    @(negedge clk);
    checks++;
    if (wr_count != w0 || resp_count != r0 || ram[4] !== 32'h80FF7F01) begin
      errors++;
      $display("FAIL rst_mid_merge_effects: writes=%0d resps=%0d ram4=%h, want 0 0 80ff7f01",
               wr_count - w0, resp_count - r0, ram[4]);
    end
  endtask

  task automatic test_illegal;
    int lat; logic [31:0] rd; logic er; int w0;
    w0 = wr_count;
    issue(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL illegal_f3_011: lat=%0d err=%b rdata=%h, want 1 1 0", lat, er, rd);
    end
    issue(1'b1, F3_BU, 32'h10, 32'h55, lat, rd, er);
    checks++;
    if (lat != 1 || er !== 1'b1 || wr_count != w0) begin
      errors++;
      $display("FAIL illegal_store_bu: lat=%0d err=%b writes=%0d, want 1 1 0", lat, er, wr_count - w0);
    end
    issue(1'b0, F3_W, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (lat != 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_after: lat=%0d err=%b, want 2 0", lat, er);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_resp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int w0;
    poke(12'd0, 32'hCAFEF00D);
    w0 = wr_count;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h4000; req_wdata = '0;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (req_ready !== exp_rdy[i] || resp_valid !== exp_resp[i] ||
          (exp_resp[i] && resp_rdata !== 32'hCAFEF00D)) begin
        errors++;
        $display("FAIL b2b_cycle_%0d: ready=%b valid=%b rdata=%h, want %b %b cafef00d",
                 i, req_ready, resp_valid, resp_rdata, exp_rdy[i], exp_resp[i]);
      end
      if (i < 5) @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_count != w0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: writes=%0d ready=%b, want 0 1", wr_count - w0, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_lanes();
    test_subword_store();
    test_misalign();
    test_reset_mid_merge();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
